// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown when no instruction is ready
//   PC_ALIGN_MASK : clears the byte-offset bits of a fetch address
//   fetchEntry_t  : one buffered fetch result, {pc, instr}
//   fetchState_t  : fetch-side response handling mode
//   pcPlus4       : sequential next-PC helper (wraps mod 2^XLEN)
package riscv_pkg;

  localparam int              XLEN          = 32;
  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP       = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetchEntry_t;

  // FS_RUN   : responses are written to the buffer
  // FS_DRAIN : responses belong to a squashed path and are dropped
  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetchState_t;

  function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch entry storage: DEPTH x {pc, instr} synchronous FIFO.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   flush      : empties the FIFO this edge; push/pop in the same cycle are ignored
//   push       : write pushData at the tail
//   pop        : advance the head (ignored when empty)
//   headData   : oldest entry (undefined contents when count == 0)
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetchEntry_t            pushData,
  input  logic                   pop,
  output fetchEntry_t            headData,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetchEntry_t   entries [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic          doPush, doPop;

  assign doPop  = pop && !flush && (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign doPush = push && !flush && ((count != FULL) || doPop);

  assign headData = entries[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) entries[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer between the PC generator and instruction memory.
// Issues sequential word fetches while credits remain (outstanding + buffered
// < DEPTH), buffers in-order responses, and presents the head to the IF stage.
// A redirect flushes the buffer, restarts fetch at the new target and drops
// every response still in flight for the old path.
//   clk, reset                           : clock, synchronous active-high reset
//   mem_req_valid/ready/addr             : fetch request channel
//   mem_rsp_valid/data                   : in-order response channel (no backpressure)
//   instr_valid/instr/pc/pc_plus4        : head entry to IF stage
//   stall                                : IF stalled, head held
//   redirect/redirect_pc                 : taken branch/jump and its target
// DEPTH: buffer entries and in-flight limit (power of two, >= 2).
module fetch_prefetch_buffer import riscv_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW:0]   LIMIT   = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetchPc, rspPc, lastPc, redirectTarget;
  logic [CW-1:0]   outstanding, count, discardCnt, discardNext;
  logic [CW:0]     inFlight;
  fetchState_t     state, stateNext;
  fetchEntry_t     head, pushEntry;
  logic            reqFire, rspAccept, popHead;

  assign redirectTarget = redirect_pc & PC_ALIGN_MASK;

  // Credits cover both in-flight requests and buffered entries, so every
  // response that is accepted always finds a free slot.
  assign inFlight      = {1'b0, outstanding} + {1'b0, count};
  assign mem_req_valid = !reset && !redirect && (inFlight < LIMIT);
  assign mem_req_addr  = fetchPc;
  assign reqFire       = mem_req_valid && mem_req_ready;

  assign rspAccept = mem_rsp_valid && !reset && !redirect && (state == FS_RUN);
  assign pushEntry = '{pc: rspPc, instr: mem_rsp_data};

  assign instr_valid    = !reset && (count != '0);
  assign popHead        = instr_valid && !stall && !redirect;
  assign instr          = instr_valid ? head.instr : NOP_INSTR;
  // With nothing buffered the PC outputs hold the last head seen, so a
  // stalled/empty IF stage sees a stable address.
  assign instr_pc       = reset ? RESET_PC : (instr_valid ? head.pc : lastPc);
  assign instr_pc_plus4 = pcPlus4(instr_pc);

  prefetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (rspAccept),
    .pushData (pushEntry),
    .pop      (popHead),
    .headData (head),
    .count    (count)
  );

  // Drain tracking: a redirect snapshots how many old-path responses are still
  // coming (the one arriving this cycle is already being dropped).
  always_comb begin
    stateNext   = state;
    discardNext = discardCnt;
    if (redirect) begin
      discardNext = outstanding - CW'(mem_rsp_valid);
      stateNext   = (discardNext != '0) ? FS_DRAIN : FS_RUN;
    end else if ((state == FS_DRAIN) && mem_rsp_valid) begin
      discardNext = discardCnt - CNT_ONE;
      stateNext   = (discardNext != '0) ? FS_DRAIN : FS_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FS_RUN;
      discardCnt <= '0;
    end else begin
      state      <= stateNext;
      discardCnt <= discardNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      lastPc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      if (instr_valid) lastPc <= head.pc;

      case ({reqFire, mem_rsp_valid})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: ;
      endcase

      if (redirect) begin
        fetchPc <= redirectTarget;
        rspPc   <= redirectTarget;
      end else begin
        if (reqFire)   fetchPc <= pcPlus4(fetchPc);
        if (rspAccept) rspPc   <= pcPlus4(rspPc);
      end
    end
  end

  // Protocol checks: responses must match a request, and the credit scheme
  // must never let an accepted response land on a full buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rsp_valid && (outstanding == '0)));
      assert (!(rspAccept && (count == FULL)));
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memReady = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;

  logic        reqValid, rspValid, instrValid;
  logic [31:0] reqAddr, rspData, instrW, instrPc, instrPcPlus4;

  logic        req2Valid, rsp2Valid, instr2Valid;
  logic [31:0] req2Addr, rsp2Data, instr2W, instr2Pc, instr2PcPlus4;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic        memV [4];
  logic [31:0] memA [4];

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Main memory: fixed latency 'lat' (1..4), responses in request order.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) memV[i] <= 1'b0;
    end else begin
      memV[0] <= reqValid && memReady;
      memA[0] <= reqAddr;
      for (int i = 1; i < 4; i++) begin
        memV[i] <= memV[i-1];
        memA[i] <= memA[i-1];
      end
    end
  end
  assign rspValid = memV[lat-1];
  assign rspData  = memData(memA[lat-1]);

  // Second memory: 1-cycle, always ready, for the wrap-around instance.
  always @(posedge clk) begin
    if (reset) begin
      rsp2Valid <= 1'b0;
      rsp2Data  <= 32'h0;
    end else begin
      rsp2Valid <= req2Valid;
      rsp2Data  <= memData(req2Addr);
    end
  end

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(reqValid), .mem_req_ready(memReady), .mem_req_addr(reqAddr),
    .mem_rsp_valid(rspValid), .mem_rsp_data(rspData),
    .instr_valid(instrValid), .instr(instrW), .instr_pc(instrPc), .instr_pc_plus4(instrPcPlus4),
    .stall(stall), .redirect(redirect), .redirect_pc(redirectPc)
  );

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .reset(reset),
    .mem_req_valid(req2Valid), .mem_req_ready(1'b1), .mem_req_addr(req2Addr),
    .mem_rsp_valid(rsp2Valid), .mem_rsp_data(rsp2Data),
    .instr_valid(instr2Valid), .instr(instr2W), .instr_pc(instr2Pc), .instr_pc_plus4(instr2PcPlus4),
    .stall(stall), .redirect(redirect), .redirect_pc(redirectPc)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle with reset low.
  task automatic doReset(input int latency);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; memReady = 1'b1; lat = latency;
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b0 || instrValid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: req=%b instr=%b, want 0 0", reqValid, instrValid);
    end
    checks++;
    if (instrW !== NOP) begin
      errors++; $display("FAIL reset_instr: got %h want %h", instrW, NOP);
    end
    checks++;
    if (instrPc !== 32'h0 || instrPcPlus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc: got %h/%h want 0/4", instrPc, instrPcPlus4);
    end
    checks++;
    if (instr2Pc !== 32'hFFFF_FFF8 || instr2PcPlus4 !== 32'hFFFF_FFFC || req2Valid !== 1'b0) begin
      errors++; $display("FAIL reset_pc2: got %h/%h req=%b want fffffff8/fffffffc 0", instr2Pc, instr2PcPlus4, req2Valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    doReset(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (reqValid !== 1'b1 || reqAddr !== 32'(4*k)) begin
        errors++; $display("FAIL stream_req k=%0d: got %b %h want 1 %h", k, reqValid, reqAddr, 32'(4*k));
      end
      checks++;
      if (instrValid !== (k >= 2)) begin
        errors++; $display("FAIL stream_valid k=%0d: got %b want %b", k, instrValid, (k >= 2));
      end
      if (k >= 2) begin
        pc = 32'(4*(k-2));
        checks++;
        if (instrPc !== pc || instrPcPlus4 !== pc + 32'd4 || instrW !== memData(pc)) begin
          errors++; $display("FAIL stream_head k=%0d: got %h/%h/%h want %h", k, instrPc, instrPcPlus4, instrW, pc);
        end
      end
      nextCycle();
    end
  endtask

  // Continues straight from test_stream: head is pc 0x10 at entry.
  task automatic test_stall();
    logic [31:0] expPc, expAddr;
    logic        expReq;
    for (int k = 0; k < 11; k++) begin
      stall = (k < 6);
      @(negedge clk);
      expPc = 32'h10 + ((k > 6) ? 32'(4*(k-6)) : 32'h0);
      checks++;
      if (instrValid !== 1'b1 || instrPc !== expPc || instrW !== memData(expPc)) begin
        errors++; $display("FAIL stall_head k=%0d: got %b %h want 1 %h", k, instrValid, instrPc, expPc);
      end
      expReq = !(k >= 2 && k <= 6);
      checks++;
      if (reqValid !== expReq) begin
        errors++; $display("FAIL stall_credit k=%0d: req=%b want %b", k, reqValid, expReq);
      end
      if (expReq) begin
        expAddr = (k < 2) ? 32'h18 + 32'(4*k) : 32'h20 + 32'(4*(k-7));
        checks++;
        if (reqAddr !== expAddr) begin
          errors++; $display("FAIL stall_addr k=%0d: got %h want %h", k, reqAddr, expAddr);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_backpressure();
    doReset(1);
    memReady = 1'b0;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b1 || reqAddr !== 32'h0 || instrValid !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got %b %h iv=%b want 1 0 0", reqValid, reqAddr, instrValid);
    end
    nextCycle();
    memReady = 1'b1;
    nextCycle();
    @(negedge clk);
    checks++;
    if (reqAddr !== 32'h4) begin
      errors++; $display("FAIL bp_advance: got %h want 4", reqAddr);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
      errors++; $display("FAIL bp_first: got %b %h want 1 0", instrValid, instrPc);
    end
  endtask

  task automatic test_redirect();
    doReset(3);
    nextCycle(); nextCycle(); nextCycle();
    redirect = 1'b1; redirectPc = 32'h200;
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b0) begin
      errors++; $display("FAIL redir_noreq: got %b want 0", reqValid);
    end
    nextCycle();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (instrValid !== 1'b0) begin
        errors++; $display("FAIL redir_drop k=%0d: instr_valid=%b pc=%h want 0", k, instrValid, instrPc);
      end
      if (k == 0) begin
        checks++;
        if (reqValid !== 1'b1 || reqAddr !== 32'h200) begin
          errors++; $display("FAIL redir_req: got %b %h want 1 200", reqValid, reqAddr);
        end
      end
      nextCycle();
    end
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h200 || instrPcPlus4 !== 32'h204 || instrW !== memData(32'h200)) begin
      errors++; $display("FAIL redir_first: got %b %h/%h/%h want 1 200/204", instrValid, instrPc, instrPcPlus4, instrW);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h204) begin
      errors++; $display("FAIL redir_second: got %b %h want 1 204", instrValid, instrPc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    doReset(1);
    nextCycle(); nextCycle(); nextCycle();
    redirect = 1'b1; redirectPc = 32'h303;
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b0 || instrValid !== 1'b1 || instrPc !== 32'h4) begin
      errors++; $display("FAIL same_redir: req=%b iv=%b pc=%h want 0 1 4", reqValid, instrValid, instrPc);
    end
    nextCycle();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0 || instrW !== NOP || instrPc !== 32'h4 || instrPcPlus4 !== 32'h8) begin
      errors++; $display("FAIL same_empty: got %b %h %h/%h want 0 nop 4/8", instrValid, instrW, instrPc, instrPcPlus4);
    end
    checks++;
    if (reqValid !== 1'b1 || reqAddr !== 32'h300) begin
      errors++; $display("FAIL same_req: got %b %h want 1 300", reqValid, reqAddr);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0 || reqAddr !== 32'h304) begin
      errors++; $display("FAIL same_gap: got %b %h want 0 304", instrValid, reqAddr);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h300 || instrW !== memData(32'h300)) begin
      errors++; $display("FAIL same_first: got %b %h %h want 1 300", instrValid, instrPc, instrW);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h304) begin
      errors++; $display("FAIL same_second: got %b %h want 1 304", instrValid, instrPc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a, pc;
    doReset(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = WRAP_PC + 32'(4*k);
      checks++;
      if (req2Valid !== 1'b1 || req2Addr !== a) begin
        errors++; $display("FAIL wrap_req k=%0d: got %b %h want 1 %h", k, req2Valid, req2Addr, a);
      end
      if (k >= 2) begin
        pc = WRAP_PC + 32'(4*(k-2));
        checks++;
        if (instr2Valid !== 1'b1 || instr2Pc !== pc || instr2PcPlus4 !== pc + 32'd4 || instr2W !== memData(pc)) begin
          errors++; $display("FAIL wrap_head k=%0d: got %b %h/%h want 1 %h", k, instr2Valid, instr2Pc, instr2PcPlus4, pc);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_reset_mid();
    doReset(3);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0 || reqValid !== 1'b0) begin
      errors++; $display("FAIL rmid_pre: got iv=%b pc=%h req=%b want 1 0 0", instrValid, instrPc, reqValid);
    end
    nextCycle();
    reset = 1'b1;
    nextCycle();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0 || reqValid !== 1'b0 || instrPc !== 32'h0) begin
      errors++; $display("FAIL rmid_reset: got iv=%b req=%b pc=%h want 0 0 0", instrValid, reqValid, instrPc);
    end
    nextCycle();
    reset = 1'b0; stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (reqValid !== 1'b1 || reqAddr !== 32'h0) begin
          errors++; $display("FAIL rmid_req: got %b %h want 1 0", reqValid, reqAddr);
        end
      end
      checks++;
      if (instrValid !== (k == 4)) begin
        errors++; $display("FAIL rmid_valid k=%0d: got %b pc=%h want %b", k, instrValid, instrPc, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (instrPc !== 32'h0 || instrW !== memData(32'h0)) begin
          errors++; $display("FAIL rmid_first: got %h %h want 0", instrPc, instrW);
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
